// File: rtl/mz_audio_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : mz_audio_conditioner
// Description : Resamples 6-bit unsigned core audio to a fixed rate, rescales
//               to signed 16 bits, then applies DC-blocking and smoothing.
// Revision    : 1.0 - initial release
// ============================================================================
module mz_audio_conditioner #(
   parameter int CLK_HZ    = 21_500_000,
   parameter int SAMPLE_HZ = 48_000,
   parameter int DC_SHIFT  = 10,
   parameter int LP_SHIFT  = 2
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic [5:0]         in_l,
   input  logic [5:0]         in_r,
   input  logic               enable,
   input  logic               mute,
   output logic signed [15:0] out_l,
   output logic signed [15:0] out_r,
   output logic               out_valid,
   output logic               busy,
   output logic               overrun
);

   localparam logic [32:0] c_inc = 33'(SAMPLE_HZ);
   localparam logic [32:0] c_mod = 33'(CLK_HZ);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CONV = 3'd1,
      S_HP   = 3'd2,
      S_LP   = 3'd3,
      S_PUB  = 3'd4
   } state_t;

   function automatic logic signed [15:0] f_sat16(input logic signed [17:0] v);
      logic signed [15:0] r;
      if (v > 18'sd32767)
         r = 16'sh7FFF;
      else if (v < -18'sd32768)
         r = 16'sh8000;
      else
         r = 16'(v);
      return r;
   endfunction

   state_t             r_state;
   logic [31:0]        r_acc;
   logic               r_ch;
   logic [5:0]         r_snap_l;
   logic [5:0]         r_snap_r;
   logic signed [16:0] r_x;
   logic signed [16:0] r_xl;
   logic signed [16:0] r_xr;
   logic signed [15:0] r_h;
   logic signed [24:0] r_dc_l;
   logic signed [24:0] r_dc_r;
   logic signed [17:0] r_lp_l;
   logic signed [17:0] r_lp_r;
   logic signed [15:0] r_yl;
   logic signed [15:0] r_yr;

   logic [32:0]        w_acc_sum;
   logic [31:0]        w_acc_next;
   logic               w_tick;
   logic [5:0]         w_in_sel;
   logic signed [16:0] w_x;
   logic signed [24:0] w_dc_cur;
   logic signed [24:0] w_x_sc;
   logic signed [25:0] w_dc_err;
   logic signed [24:0] w_dc_new;
   logic signed [17:0] w_h_raw;
   logic signed [17:0] w_lp_cur;
   logic signed [18:0] w_lp_err;
   logic signed [17:0] w_lp_new;
   logic signed [15:0] w_y;

   // Fractional-N tick: remainder carried in the accumulator, so no drift.
   assign w_acc_sum  = {1'b0, r_acc} + c_inc;
   assign w_tick     = (w_acc_sum >= c_mod);
   assign w_acc_next = w_tick ? 32'(w_acc_sum - c_mod) : 32'(w_acc_sum);

   assign w_in_sel = r_ch ? r_snap_r : r_snap_l;
   assign w_x      = $signed({1'b0, w_in_sel, 10'd0}) - 17'sd32768;

   // DC tracker holds 8 fractional bits; h uses the value before this update.
   assign w_dc_cur = r_ch ? r_dc_r : r_dc_l;
   assign w_x_sc   = {r_x, 8'd0};
   assign w_dc_err = {w_x_sc[24], w_x_sc} - {w_dc_cur[24], w_dc_cur};
   assign w_dc_new = w_dc_cur + 25'(w_dc_err >>> DC_SHIFT);
   assign w_h_raw  = {r_x[16], r_x} - 18'(w_dc_cur >>> 8);

   assign w_lp_cur = r_ch ? r_lp_r : r_lp_l;
   assign w_lp_err = {{3{r_h[15]}}, r_h} - {w_lp_cur[17], w_lp_cur};
   assign w_lp_new = w_lp_cur + 18'(w_lp_err >>> LP_SHIFT);
   assign w_y      = f_sat16(w_lp_new);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_acc     <= '0;
         r_ch      <= 1'b0;
         r_snap_l  <= '0;
         r_snap_r  <= '0;
         r_x       <= '0;
         r_xl      <= '0;
         r_xr      <= '0;
         r_h       <= '0;
         r_dc_l    <= '0;
         r_dc_r    <= '0;
         r_lp_l    <= '0;
         r_lp_r    <= '0;
         r_yl      <= '0;
         r_yr      <= '0;
         out_l     <= '0;
         out_r     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         r_acc     <= w_acc_next;
         out_valid <= 1'b0;
         if (w_tick && (r_state != S_IDLE))
            overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_tick) begin
                  r_snap_l <= in_l;
                  r_snap_r <= in_r;
                  r_ch     <= 1'b0;
                  busy     <= 1'b1;
                  r_state  <= S_CONV;
               end
            end
            S_CONV: begin
               r_x <= w_x;
               if (r_ch)
                  r_xr <= w_x;
               else
                  r_xl <= w_x;
               r_state <= S_HP;
            end
            S_HP: begin
               r_h <= f_sat16(w_h_raw);
               if (r_ch)
                  r_dc_r <= w_dc_new;
               else
                  r_dc_l <= w_dc_new;
               r_state <= S_LP;
            end
            S_LP: begin
               if (r_ch) begin
                  r_lp_r  <= w_lp_new;
                  r_yr    <= w_y;
                  r_state <= S_PUB;
               end else begin
                  r_lp_l  <= w_lp_new;
                  r_yl    <= w_y;
                  r_ch    <= 1'b1;
                  r_state <= S_CONV;
               end
            end
            S_PUB: begin
               // enable/mute are sampled here only, so outputs hold between samples.
               out_l     <= mute ? 16'sd0 : (enable ? r_yl : f_sat16({r_xl[16], r_xl}));
               out_r     <= mute ? 16'sd0 : (enable ? r_yr : f_sat16({r_xr[16], r_xr}));
               out_valid <= 1'b1;
               busy      <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
